// File: rtl/if_id_skid.sv
// Fetch-to-decode pipeline register built as a 2-entry skid buffer with
// valid/ready handshakes on both sides, synchronous flush and a NOP when empty.
module if_id_skid #(
  parameter int unsigned          INS_W    = 32,
  parameter int unsigned          ADDR_W   = 32,
  parameter logic [INS_W-1:0]     NOP_INS  = INS_W'(32'h0000_0013),
  parameter logic [ADDR_W-1:0]    ADDR_RST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [INS_W-1:0]  ins_i,
  input  logic [ADDR_W-1:0] ins_addr_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic [INS_W-1:0]  ins_o,
  output logic [ADDR_W-1:0] ins_addr_o,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        count_o
);

  logic [INS_W-1:0]  h_ins_q, h_ins_d, s_ins_q, s_ins_d;
  logic [ADDR_W-1:0] h_addr_q, h_addr_d, s_addr_q, s_addr_d;
  logic [1:0]        count_q, count_d;
  logic              push, pop;

  // Handshake outputs depend on registered count only.
  always_comb begin
    in_ready   = (count_q != 2'd2);
    out_valid  = (count_q != 2'd0);
    ins_o      = out_valid ? h_ins_q  : NOP_INS;
    ins_addr_o = out_valid ? h_addr_q : ADDR_RST;
    count_o    = count_q;
    push       = in_valid & in_ready;
    pop        = out_valid & out_ready;
  end

  always_comb begin
    h_ins_d  = h_ins_q;
    h_addr_d = h_addr_q;
    s_ins_d  = s_ins_q;
    s_addr_d = s_addr_q;
    count_d  = count_q;
    if (flush) begin
      // Held and incoming entries are dropped; a same-cycle pop is simply consumed.
      count_d = 2'd0;
    end else begin
      case (count_q)
        2'd0: begin
          if (push) begin
            h_ins_d  = ins_i;
            h_addr_d = ins_addr_i;
            count_d  = 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            h_ins_d  = ins_i;
            h_addr_d = ins_addr_i;
          end else if (push) begin
            s_ins_d  = ins_i;
            s_addr_d = ins_addr_i;
            count_d  = 2'd2;
          end else if (pop) begin
            count_d = 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            h_ins_d  = s_ins_q;
            h_addr_d = s_addr_q;
            count_d  = 2'd1;
          end
        end
        default: count_d = 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      h_ins_q  <= NOP_INS;
      h_addr_q <= ADDR_RST;
      s_ins_q  <= NOP_INS;
      s_addr_q <= ADDR_RST;
      count_q  <= 2'd0;
    end else begin
      h_ins_q  <= h_ins_d;
      h_addr_q <= h_addr_d;
      s_ins_q  <= s_ins_d;
      s_addr_q <= s_addr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_if_id_skid.sv
// Directed bench for if_id_skid: table of single-cycle vectors plus
// hand-written streaming and long-stall sequences.
module tb_if_id_skid;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ins_i, ins_addr_i;
  logic        in_valid, in_ready, flush;
  logic [31:0] ins_o, ins_addr_o;
  logic        out_valid, out_ready;
  logic [1:0]  count_o;

  int n_vec = 0;
  int n_miscmp = 0;

  if_id_skid dut (
    .clk       (clk),
    .rst       (rst),
    .ins_i     (ins_i),
    .ins_addr_i(ins_addr_i),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .ins_o     (ins_o),
    .ins_addr_o(ins_addr_o),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count_o   (count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [31:0] addr;
    logic        fl;
    logic        ordy;
    logic        e_ov;
    logic        e_ir;
    logic [31:0] e_ins;
    logic [31:0] e_addr;
    logic [1:0]  e_cnt;
  } vec_t;

  function automatic logic [31:0] ins_of(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  // Expected outputs: an entry at addr a carries ins_of(a); empty shows NOP/0.
  function automatic vec_t mk(input logic r, input logic iv, input logic [31:0] a,
                              input logic fl, input logic ordy, input logic [1:0] cnt,
                              input logic [31:0] head);
    vec_t v;
    v.rst    = r;
    v.iv     = iv;
    v.addr   = a;
    v.fl     = fl;
    v.ordy   = ordy;
    v.e_cnt  = cnt;
    v.e_ov   = (cnt != 2'd0);
    v.e_ir   = (cnt != 2'd2);
    v.e_ins  = v.e_ov ? ins_of(head) : 32'h0000_0013;
    v.e_addr = v.e_ov ? head : 32'h0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input int idx);
    @(negedge clk);
    rst        = v.rst;
    in_valid   = v.iv;
    ins_addr_i = v.addr;
    ins_i      = ins_of(v.addr);
    flush      = v.fl;
    out_ready  = v.ordy;
    @(posedge clk);
    #1;
    n_vec++;
    chk($sformatf("v%0d out_valid", idx), {31'b0, out_valid}, {31'b0, v.e_ov});
    chk($sformatf("v%0d in_ready", idx), {31'b0, in_ready}, {31'b0, v.e_ir});
    chk($sformatf("v%0d ins_o", idx), ins_o, v.e_ins);
    chk($sformatf("v%0d ins_addr_o", idx), ins_addr_o, v.e_addr);
    chk($sformatf("v%0d count_o", idx), {30'b0, count_o}, {30'b0, v.e_cnt});
  endtask

  // Invariants checked every cycle just after the edge.
  logic        p_ov = 1'b0;
  logic [31:0] p_ins, p_addr;
  always @(posedge clk) begin
    #1;
    if (count_o == 2'd3) begin
      n_miscmp++;
      $display("FAIL count_o_range: got %0d expected at most 2", count_o);
    end
    if (p_ov && !out_ready && rst && !flush) begin
      if (ins_o !== p_ins || ins_addr_o !== p_addr) begin
        n_miscmp++;
        $display("FAIL stall_stable: got %h/%h expected %h/%h", ins_o, ins_addr_o, p_ins,
                 p_addr);
      end
    end
    p_ov   = out_valid;
    p_ins  = ins_o;
    p_addr = ins_addr_o;
  end

  vec_t vt[$];
  vec_t v;

  initial begin
    rst = 1'b0; in_valid = 1'b0; ins_i = '0; ins_addr_i = '0; flush = 1'b0; out_ready = 1'b0;

    //             rst iv addr       fl ordy cnt head
    // Reset then idle
    vt.push_back(mk(0, 0, 32'h0,     0, 0, 0, 32'h0));
    vt.push_back(mk(0, 0, 32'h0,     0, 0, 0, 32'h0));
    vt.push_back(mk(1, 0, 32'h0,     0, 0, 0, 32'h0));
    // Streaming, 1-cycle lag
    vt.push_back(mk(1, 1, 32'h0,     0, 1, 1, 32'h0));
    vt.push_back(mk(1, 1, 32'h4,     0, 1, 1, 32'h4));
    vt.push_back(mk(1, 1, 32'h8,     0, 1, 1, 32'h8));
    vt.push_back(mk(1, 0, 32'h0,     0, 1, 0, 32'h0));
    // Backpressure; push while full is ignored
    vt.push_back(mk(1, 1, 32'h100,   0, 0, 1, 32'h100));
    vt.push_back(mk(1, 1, 32'h104,   0, 0, 2, 32'h100));
    vt.push_back(mk(1, 1, 32'h108,   0, 0, 2, 32'h100));
    vt.push_back(mk(1, 0, 32'h0,     0, 1, 1, 32'h104));
    vt.push_back(mk(1, 0, 32'h0,     0, 1, 0, 32'h0));
    // Flush with full buffer and a push attempt
    vt.push_back(mk(1, 1, 32'h1F0,   0, 0, 1, 32'h1F0));
    vt.push_back(mk(1, 1, 32'h1F4,   0, 0, 2, 32'h1F0));
    vt.push_back(mk(1, 1, 32'h200,   1, 0, 0, 32'h0));
    vt.push_back(mk(1, 0, 32'h0,     0, 1, 0, 32'h0));
    // Push+pop at count 1
    vt.push_back(mk(1, 1, 32'h300,   0, 0, 1, 32'h300));
    vt.push_back(mk(1, 1, 32'h304,   0, 1, 1, 32'h304));
    vt.push_back(mk(1, 0, 32'h0,     0, 0, 1, 32'h304));
    // Reset mid-backpressure
    vt.push_back(mk(1, 1, 32'h400,   0, 0, 2, 32'h304));
    vt.push_back(mk(0, 1, 32'h404,   0, 1, 0, 32'h0));
    vt.push_back(mk(1, 0, 32'h0,     0, 1, 0, 32'h0));
    // Flush with pop and push at count 1
    vt.push_back(mk(1, 1, 32'h500,   0, 0, 1, 32'h500));
    vt.push_back(mk(1, 1, 32'h504,   1, 1, 0, 32'h0));
    // Pop at count 2 with in_valid high: push refused
    vt.push_back(mk(1, 1, 32'h600,   0, 0, 1, 32'h600));
    vt.push_back(mk(1, 1, 32'h604,   0, 0, 2, 32'h600));
    vt.push_back(mk(1, 1, 32'h608,   0, 1, 1, 32'h604));
    vt.push_back(mk(1, 0, 32'h0,     0, 1, 0, 32'h0));

    for (int i = 0; i < vt.size(); i++) step(vt[i], i);

    // Longer stream: each pushed address appears on the next cycle.
    for (int i = 0; i < 8; i++) begin
      v = mk(1, 1, 32'h700 + 32'(4 * i), 0, 1, 1, 32'h700 + 32'(4 * i));
      step(v, 100 + i);
    end
    step(mk(1, 0, 32'h0, 0, 1, 0, 32'h0), 108);

    // Long stall at full: head and skid both survive, then drain in order.
    step(mk(1, 1, 32'h800, 0, 0, 1, 32'h800), 200);
    step(mk(1, 1, 32'h804, 0, 0, 2, 32'h800), 201);
    for (int i = 0; i < 5; i++) step(mk(1, i[0], 32'h900, 0, 0, 2, 32'h800), 202 + i);
    step(mk(1, 0, 32'h0, 0, 1, 1, 32'h804), 207);
    step(mk(1, 1, 32'h808, 0, 0, 2, 32'h804), 208);
    step(mk(1, 0, 32'h0, 0, 1, 1, 32'h808), 209);
    step(mk(1, 0, 32'h0, 0, 1, 0, 32'h0), 210);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/if_id_skid.md
Name: if_id_skid

Overview:
Parametrised successor to the fetch-to-decode pipeline register. It carries instruction word and instruction address from fetch to decode through a 2-entry skid buffer with valid/ready handshakes on both sides. Stall is expressed through backpressure (out_ready low), not by discarding data. Flush is a separate input that invalidates all buffered entries and presents a NOP to decode.

Parameters:
INS_W, 32, instruction word width in bits
ADDR_W, 32, instruction address width in bits
NOP_INS, 32'h0000_0013, word presented on ins_o when no valid entry is held (INS_W bits)
ADDR_RST, 0, value presented on ins_addr_o when no valid entry is held (ADDR_W bits)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-low
ins_i  input  INS_W  instruction from fetch
ins_addr_i  input  ADDR_W  address of ins_i
in_valid  input  1  fetch presents a valid instruction
in_ready  output  1  buffer can accept this cycle
flush  input  1  discard all held and incoming entries (branch/jump redirect)
ins_o  output  INS_W  instruction to decode
ins_addr_o  output  ADDR_W  address of ins_o
out_valid  output  1  ins_o/ins_addr_o hold a valid entry
out_ready  input  1  decode consumes the entry this cycle
count_o  output  2  number of held entries, 0..2

Behaviour:
- Storage: two entries, head (H) and skid (S), each holding {ins, addr}, plus a 2-bit count register. No other state.
- Transfers:
  - push = in_valid & in_ready
  - pop = out_valid & out_ready
  - Both are evaluated each cycle and take effect at the rising edge.
- in_ready = (count != 2). Combinational from registered count only; never depends on in_valid or out_ready.
- out_valid = (count != 0).
- Outputs when count == 0: ins_o = NOP_INS, ins_addr_o = ADDR_RST. Otherwise they show the H entry. All outputs are driven from registers or from count decode, with no combinational path from inputs.
- Latency: an entry pushed at edge N appears on ins_o after edge N, so out_valid rises 1 cycle after acceptance. No bypass.
- Ordering: strict FIFO, with H always the oldest entry.
- Count transitions (no flush):
  - count 0: push -> H=in, count 1.
  - count 1, push only: S=in, count 2.
  - count 1, pop only: count 0.
  - count 1, push+pop: H=in, count 1.
  - count 2, pop: H=S, count 1. Push is impossible because in_ready=0.
  - count 2, no pop: hold.
- Hold: when there is neither push nor pop, H, S and count keep their values. This replaces the old hold-inserts-NOP behaviour; a stalled instruction is never lost.
- Flush (flush=1 at edge): count -> 0. H and S contents are don't-care, but outputs show NOP_INS/ADDR_RST. Any push in the same cycle is discarded, even though in_ready may be 1. A pop in the same cycle still counts as consumed by decode. Flush has priority over push and pop.
- Reset (rst=0 at edge): count -> 0 and H/S cleared to NOP_INS/ADDR_RST. Resulting output values:
  - out_valid = 0
  - in_ready = 1
  - ins_o = NOP_INS
  - ins_addr_o = ADDR_RST
  - count_o = 0
- Reset has priority over flush. Reset asserted mid-transfer drops all entries with no partial update.
- Width rules: ins and addr are stored and forwarded unmodified. Only count arithmetic exists; it saturates by construction and must never wrap from 2 to 3 or from 0 to 3.
- Assertions for the bench:
  - count_o is never 3.
  - While out_valid=1 and out_ready=0, ins_o and ins_addr_o are stable.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, then rst=1 -> out_valid=0, in_ready=1, ins_o=32'h13, ins_addr_o=0, count_o=0.
- Streaming: out_ready=1 and in_valid=1 every cycle with addr 0x0,0x4,0x8,... -> ins_addr_o sequence 0x0,0x4,0x8 with 1-cycle lag, count_o stays 1, in_ready stays 1.
- Backpressure: push A(0x100), B(0x104) with out_ready=0 -> count_o=2, in_ready=0, ins_addr_o=0x100 held. Raise out_ready -> 0x100 then 0x104 delivered, count_o goes 1 then 0.
- Flush with full buffer: count_o=2, flush=1 with in_valid=1 addr 0x200 -> next cycle count_o=0, out_valid=0, ins_o=32'h13, 0x200 never appears.
- Simultaneous push+pop at count 1: H=0x300, push 0x304 with out_ready=1 -> next cycle count_o=1, ins_addr_o=0x304.
- Reset mid-backpressure: count_o=2, rst=0 one cycle -> count_o=0, in_ready=1, previously held entries never output.
